// File: rtl/quad_decoder.sv
// quad_decoder: quadrature (A/B) encoder decoder.
//
// Turns two asynchronous encoder channels into a one-cycle step pulse plus a
// direction, ready to drive an up/down counter's en_i/dir_i directly.
// Datapath per channel: SYNC_STAGES-deep synchroniser -> glitch filter that
// needs FILT_LEN consecutive differing cycles before accepting a new level.
// The filtered {A,B} pair feeds a phase decoder that reports legal steps and
// illegal (both-bits-changed) transitions, the latter counted in a
// saturating counter.
//
// Ports:
//   clk_i      in   clock
//   rst_i      in   synchronous, active-high reset
//   en_i       in   enables step/error reporting (filters keep tracking)
//   a_i, b_i   in   encoder channels, asynchronous
//   clr_err_i  in   synchronous clear of err_cnt_o (wins over an increment)
//   step_o     out  one-cycle pulse per legal transition
//   dir_o      out  direction of the most recent legal step (count_dir_e)
//   error_o    out  one-cycle pulse per illegal transition
//   err_cnt_o  out  saturating count of illegal transitions
//   state_o    out  filtered {A,B}

package counter_pkg;
  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } count_dir_e;
endpackage

module quad_decoder
  import counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             clr_err_i,
  output logic             step_o,
  output count_dir_e       dir_o,
  output logic             error_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [1:0]       state_o
);

  // Filter counter only has to reach FILT_LEN-1; the FILT_LEN-th differing
  // cycle is the one that accepts the new level.
  localparam int FCW     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int PRIME_N = SYNC_STAGES + FILT_LEN;
  localparam int PCW     = $clog2(PRIME_N + 1);

  logic [1:0]       raw;
  logic [1:0]       filt_q, filt_d;
  logic [PCW-1:0]   prime_cnt_q, prime_cnt_d;
  logic             primed;
  logic             step_q, step_d;
  logic             error_q, error_d;
  count_dir_e       dir_q, dir_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             legal_up, legal_dn, illegal;

  // Bit 1 carries channel A, bit 0 channel B, matching state_o = {A,B}.
  assign raw = {a_i, b_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [FCW-1:0]         cnt_q, cnt_d;
      logic                   filt_bit_d;

      always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], raw[gi]};
        cnt_d      = '0;
        filt_bit_d = filt_q[gi];
        if (sync_q[SYNC_STAGES-1] != filt_q[gi]) begin
          if (cnt_q == FCW'(FILT_LEN - 1)) begin
            filt_bit_d = sync_q[SYNC_STAGES-1];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sync_q <= '0;
          cnt_q  <= '0;
        end else begin
          sync_q <= sync_d;
          cnt_q  <= cnt_d;
        end
      end

      assign filt_d[gi] = filt_bit_d;
    end
  endgenerate

  // Next phase in the UP direction: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] up_next(input logic [1:0] s);
    case (s)
      2'b00:   up_next = 2'b10;
      2'b10:   up_next = 2'b11;
      2'b11:   up_next = 2'b01;
      default: up_next = 2'b00;
    endcase
  endfunction

  // filt_q is the previous decoded phase and filt_d the one being accepted
  // this cycle, so step/error register on the same edge as the new phase.
  assign legal_up = (filt_d == up_next(filt_q));
  assign legal_dn = (filt_q == up_next(filt_d));
  assign illegal  = ((filt_d ^ filt_q) == 2'b11);
  assign primed   = (prime_cnt_q == PCW'(PRIME_N));

  always_comb begin
    prime_cnt_d = prime_cnt_q;
    step_d      = 1'b0;
    error_d     = 1'b0;
    dir_d       = dir_q;
    err_cnt_d   = err_cnt_q;

    // Until the synchronisers and filters have settled, the phase register
    // just follows the filter so a non-idle input level at reset is silent.
    if (!primed) begin
      prime_cnt_d = prime_cnt_q + 1'b1;
    end else if (en_i) begin
      if (legal_up) begin
        step_d = 1'b1;
        dir_d  = UP;
      end else if (legal_dn) begin
        step_d = 1'b1;
        dir_d  = DOWN;
      end else if (illegal) begin
        error_d = 1'b1;
      end
    end

    if (clr_err_i) begin
      err_cnt_d = '0;
    end else if (error_d && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q      <= '0;
      prime_cnt_q <= '0;
      step_q      <= 1'b0;
      error_q     <= 1'b0;
      dir_q       <= UP;
      err_cnt_q   <= '0;
    end else begin
      filt_q      <= filt_d;
      prime_cnt_q <= prime_cnt_d;
      step_q      <= step_d;
      error_q     <= error_d;
      dir_q       <= dir_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign step_o    = step_q;
  assign error_o   = error_q;
  assign dir_o     = dir_q;
  assign err_cnt_o = err_cnt_q;
  assign state_o   = filt_q;

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature (A/B) decoder that turns two asynchronous encoder channels into a one-cycle step pulse plus direction.
- step_o/dir_o connect directly to an up/down counter's en_i/dir_i. dir_o uses count_dir_e from counter_pkg.
- Contains input synchronisers, per-channel glitch filters, a phase decoder and a saturating illegal-transition counter.

Parameters:
- SYNC_STAGES, 2, synchroniser depth per channel (min 2).
- FILT_LEN, 4, consecutive cycles a synchronised level must differ from the filtered level before it is accepted (min 1; 1 = no filtering).
- ERR_W, 8, width of the illegal-transition counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  enables step/error reporting.
- a_i  in  1  encoder channel A, asynchronous.
- b_i  in  1  encoder channel B, asynchronous.
- clr_err_i  in  1  synchronous clear of err_cnt_o.
- step_o  out  1  one-cycle pulse per legal transition.
- dir_o  out  count_dir_e (1)  direction of the most recent legal step.
- error_o  out  1  one-cycle pulse on an illegal transition.
- err_cnt_o  out  ERR_W  saturating count of illegal transitions.
- state_o  out  2  filtered {A,B}.

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst_i; all registers use it.
- Reset values: step_o=0, dir_o=UP, error_o=0, err_cnt_o=0, state_o=00. Synchroniser flops, filter counters and the primed flag all clear.
- Synchroniser: a_i and b_i each pass through SYNC_STAGES flops.
- Filter, per channel:
  - Counter increments each cycle the synchronised bit differs from the filtered bit.
  - Counter clears when the two bits are equal.
  - On the FILT_LEN-th consecutive differing cycle, the filtered bit takes the new value and the counter clears.
  - Pulses shorter than FILT_LEN cycles never reach the filtered bit.
- Priming:
  - The primed flag clears on reset.
  - For the first SYNC_STAGES+FILT_LEN cycles after rst_i deasserts, the decoder state register loads the filtered value with no step and no error.
  - primed then sets.
  - Purpose: a nonzero input level at reset must not produce an error.
- Decoder: prev = registered filtered {A,B}; cur = current filtered {A,B}. Every cycle prev <= cur, independent of en_i.
  - UP sequence: 00->10->11->01->00. A legal UP transition gives step_o=1, dir_o<=UP.
  - DOWN is the reverse: 00->01->11->10->00. A legal DOWN transition gives step_o=1, dir_o<=DOWN.
  - cur==prev: no action.
  - Both bits change (00<->11, 01<->10): error_o=1, no step, dir_o unchanged.
- en_i=0: step_o and error_o forced to 0 and err_cnt_o does not increment. Synchroniser, filter and prev still track, so re-enabling causes no spurious step.
- Latency: step_o or error_o is high in the cycle after the (SYNC_STAGES+FILT_LEN)-th rising edge following the edge that first samples the new input level. This is 6 with defaults.
- Throughput: at most one legal transition per FILT_LEN cycles per channel. Faster inputs are undefined, but the block must not lock up.
- err_cnt_o:
  - Increments on error_o and saturates at 2^ERR_W-1.
  - clr_err_i clears it. clr_err_i in the same cycle as error_o gives 0 (clear wins).
- dir_o holds between steps.
- Reset mid-operation: all state returns to reset values on the next edge, and priming restarts.

Test Plan:
- Reset, a=b=0, then step the inputs 00->10->11->01->00 with each level held 10 cycles -> 4 step_o pulses, dir_o=UP, each pulse 6 edges after the change, err_cnt_o=0.
- Apply the reverse sequence 00->01->11->10->00 -> 4 pulses, dir_o=DOWN. Then one UP transition -> dir_o returns to UP on that pulse.
- a_i high for 3 cycles from 00 -> no step, state_o stays 00. a_i high for 4 cycles -> exactly one UP step, then one DOWN step when A falls (after its own 4-cycle filter).
- From state 00 drive a and b high in the same cycle -> error_o one pulse, no step, err_cnt_o=1. Then clr_err_i with a coincident error -> err_cnt_o=0.
- ERR_W=2, five illegal transitions -> err_cnt_o reads 1,2,3,3,3.
- Hold a=b=1 through reset -> after priming, state_o=11, no error_o, no step_o. Then en_i=0 during one UP transition -> no step. Re-enable and make one further UP transition -> exactly one step.
